// File: rtl/bus_b_pkg.sv
// bus_b_pkg: shared constants for the bus-B source multiplexer / arbiter.
//   - source indices of the processor's bus-B sources
//   - mode encoding for MODE input
//   - arbiter state encoding
package bus_b_pkg;

    // Bus-B source indices.
    localparam int SRC_RAM   = 0;
    localparam int SRC_PC    = 1;
    localparam int SRC_R1    = 2;
    localparam int SRC_R2    = 3;
    localparam int SRC_TR    = 4;
    localparam int SRC_R     = 5;
    localparam int SRC_AC    = 6;
    localparam int SRC_INSTR = 7;

    // MODE input encoding.
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_ARB    = 1'b1;

    // Arbiter state.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

endpackage

// File: rtl/bus_b_rr_pick.sv
// bus_b_rr_pick: combinational round-robin picker.
// Returns the first requesting index scanning ptr, ptr+1, ..., N_SRC-1, 0, ..., ptr-1.
// Ports:
//   req   in  N_SRC  request vector
//   ptr   in  SEL_W  scan start index (must be < N_SRC)
//   idx   out SEL_W  picked index (0 when nothing found)
//   found out 1      at least one request present
module bus_b_rr_pick #(
    parameter int N_SRC = 8,
    parameter int SEL_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            int i;
            i = int'(ptr) + k;
            if (i >= N_SRC) i = i - N_SRC;
            if (!found && req[i]) begin
                found = 1'b1;
                idx   = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_b_mux_arbiter.sv
// bus_b_mux_arbiter: registered bus-B source multiplexer with a direct-select
// mode and a round-robin arbitrated mode with bounded hold time.
// Ports:
//   CLOCK      in   system clock (rising edge)
//   RESET_N    in   synchronous active-low reset
//   MODE       in   0 = direct select, 1 = arbitrated
//   SELECT     in   source index for direct mode
//   SEL_VALID  in   SELECT valid this cycle
//   REQ        in   per-source request (arbitrated mode)
//   SRC_DATA   in   flattened source data, source i at [i*DATA_W +: DATA_W]
//   BUS        out  registered bus value
//   BUS_VALID  out  BUS freshly selected this cycle
//   GRANT      out  one-hot current owner (arbitrated mode)
//   OWNER      out  last selected / granted source index
//   SEL_ERR    out  one-cycle pulse on out-of-range direct SELECT
module bus_b_mux_arbiter
    import bus_b_pkg::*;
#(
    parameter int               N_SRC       = 8,
    parameter int               DATA_W      = 16,
    parameter int               NARROW_W    = 8,
    parameter logic [N_SRC-1:0] NARROW_MASK = N_SRC'((1 << SRC_RAM) | (1 << SRC_INSTR)),
    parameter int               MAX_HOLD    = 4,
    parameter int               SEL_W       = $clog2(N_SRC)
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    input  logic                    MODE,
    input  logic [SEL_W-1:0]        SELECT,
    input  logic                    SEL_VALID,
    input  logic [N_SRC-1:0]        REQ,
    input  logic [N_SRC*DATA_W-1:0] SRC_DATA,
    output logic [DATA_W-1:0]       BUS,
    output logic                    BUS_VALID,
    output logic [N_SRC-1:0]        GRANT,
    output logic [SEL_W-1:0]        OWNER,
    output logic                    SEL_ERR
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    // Low-NARROW_W-bit mask; built by subtraction so NARROW_W == DATA_W also works.
    localparam logic [DATA_W:0]   ONE_X    = (DATA_W+1)'(1) << NARROW_W;
    localparam logic [DATA_W-1:0] LOW_MASK = DATA_W'(ONE_X - 1'b1);

    state_t             st;
    logic [SEL_W-1:0]   ptr;
    logic [CNT_W-1:0]   cnt;

    // Extended source values; narrow sources are masked so their upper bits
    // can never reach the bus.
    logic [N_SRC-1:0][DATA_W-1:0] src_ext;

    for (genvar g = 0; g < N_SRC; g++) begin : g_ext
        assign src_ext[g] = NARROW_MASK[g] ? (SRC_DATA[g*DATA_W +: DATA_W] & LOW_MASK)
                                           :  SRC_DATA[g*DATA_W +: DATA_W];
    end

    // Index following the current owner, modulo N_SRC.
    logic [SEL_W-1:0] nxt_owner;
    always_comb begin
        nxt_owner = (int'(OWNER) + 1 >= N_SRC) ? '0 : SEL_W'(int'(OWNER) + 1);
    end

    // IDLE scans from PTR; OWNED scans from the slot after the owner.
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    assign pick_ptr = (st == ST_OWNED) ? nxt_owner : ptr;

    bus_b_rr_pick #(.N_SRC(N_SRC), .SEL_W(SEL_W)) u_pick (
        .req   (REQ),
        .ptr   (pick_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    logic [N_SRC-1:0] owner_oh;
    logic             others_req;
    assign owner_oh   = N_SRC'(1) << OWNER;
    assign others_req = |(REQ & ~owner_oh);

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            BUS       <= '0;
            BUS_VALID <= 1'b0;
            GRANT     <= '0;
            OWNER     <= '0;
            SEL_ERR   <= 1'b0;
            st        <= ST_IDLE;
            ptr       <= '0;
            cnt       <= '0;
        end else begin
            BUS_VALID <= 1'b0;
            SEL_ERR   <= 1'b0;
            if (st == ST_OWNED && MODE != MODE_ARB) begin
                // Mode left arbitration: release this edge, new mode acts next edge.
                GRANT <= '0;
                st    <= ST_IDLE;
            end else if (MODE == MODE_DIRECT) begin
                if (SEL_VALID) begin
                    if (int'(SELECT) < N_SRC) begin
                        BUS       <= src_ext[SELECT];
                        BUS_VALID <= 1'b1;
                        OWNER     <= SELECT;
                    end else begin
                        SEL_ERR <= 1'b1;
                    end
                end
            end else if (st == ST_IDLE) begin
                if (pick_found) begin
                    GRANT     <= N_SRC'(1) << pick_idx;
                    OWNER     <= pick_idx;
                    BUS       <= src_ext[pick_idx];
                    BUS_VALID <= 1'b1;
                    cnt       <= CNT_W'(1);
                    st        <= ST_OWNED;
                end
            end else if (!REQ[OWNER]) begin
                // Owner released: hand off with no dead cycle if anyone waits.
                ptr <= nxt_owner;
                if (others_req) begin
                    GRANT     <= N_SRC'(1) << pick_idx;
                    OWNER     <= pick_idx;
                    BUS       <= src_ext[pick_idx];
                    BUS_VALID <= 1'b1;
                    cnt       <= CNT_W'(1);
                end else begin
                    GRANT <= '0;
                    st    <= ST_IDLE;
                end
            end else if (cnt == CNT_W'(MAX_HOLD) && others_req) begin
                // Hold limit reached with contention: forced rotation.
                ptr       <= nxt_owner;
                GRANT     <= N_SRC'(1) << pick_idx;
                OWNER     <= pick_idx;
                BUS       <= src_ext[pick_idx];
                BUS_VALID <= 1'b1;
                cnt       <= CNT_W'(1);
            end else begin
                // Keep ownership; bus follows the owner's live data.
                BUS       <= src_ext[OWNER];
                BUS_VALID <= 1'b1;
                if (cnt != CNT_W'(MAX_HOLD)) cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_bus_b_mux_arbiter.sv
// Scoreboard bench for bus_b_mux_arbiter. Stimulus pushes the expected
// registered outputs for each edge; the monitor pops and compares after it.
// A second 6-source instance shares the inputs to reach out-of-range SELECT.
module tb_bus_b_mux_arbiter;
    import bus_b_pkg::*;

    logic              CLOCK = 1'b0;
    logic              RESET_N;
    logic              MODE;
    logic [2:0]        SELECT;
    logic              SEL_VALID;
    logic [7:0]        REQ;
    logic [7:0][15:0]  src;
    logic [5:0][15:0]  src6;

    logic [15:0] bus, bus6;
    logic        bus_valid, bus_valid6;
    logic [7:0]  grant;
    logic [5:0]  grant6;
    logic [2:0]  owner, owner6;
    logic        sel_err, sel_err6;

    assign src6 = src[5:0];

    always #5 CLOCK = ~CLOCK;

    bus_b_mux_arbiter dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .MODE(MODE), .SELECT(SELECT),
        .SEL_VALID(SEL_VALID), .REQ(REQ), .SRC_DATA(src),
        .BUS(bus), .BUS_VALID(bus_valid), .GRANT(grant), .OWNER(owner),
        .SEL_ERR(sel_err)
    );

    bus_b_mux_arbiter #(.N_SRC(6), .NARROW_MASK(6'b00_0001)) dut6 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .MODE(MODE), .SELECT(SELECT),
        .SEL_VALID(SEL_VALID), .REQ(REQ[5:0]), .SRC_DATA(src6),
        .BUS(bus6), .BUS_VALID(bus_valid6), .GRANT(grant6), .OWNER(owner6),
        .SEL_ERR(sel_err6)
    );

    typedef struct {
        logic [15:0] bus;
        logic        bv;
        logic [7:0]  grant;
        logic [2:0]  owner;
        logic        c6;
        logic [15:0] bus6;
        logic        bv6;
        logic        se6;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per edge, sampled 1ns after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("bus",       32'(bus),       32'(e.bus));
                chk("bus_valid", 32'(bus_valid), 32'(e.bv));
                chk("grant",     32'(grant),     32'(e.grant));
                chk("owner",     32'(owner),     32'(e.owner));
                chk("sel_err",   32'(sel_err),   32'(1'b0));
                if (e.c6) begin
                    chk("bus6",       32'(bus6),       32'(e.bus6));
                    chk("bus_valid6", 32'(bus_valid6), 32'(e.bv6));
                    chk("sel_err6",   32'(sel_err6),   32'(e.se6));
                end
            end
        end
    end

    function automatic exp_t mk(logic [15:0] b, logic v, logic [7:0] g, logic [2:0] o);
        exp_t e;
        e.bus = b; e.bv = v; e.grant = g; e.owner = o;
        e.c6 = 1'b0; e.bus6 = '0; e.bv6 = 1'b0; e.se6 = 1'b0;
        return e;
    endfunction

    function automatic exp_t with6(exp_t e, logic [15:0] b6, logic v6, logic s6);
        exp_t r;
        r = e; r.c6 = 1'b1; r.bus6 = b6; r.bv6 = v6; r.se6 = s6;
        return r;
    endfunction

    task automatic cyc(input exp_t e);
        q.push_back(e);
        @(negedge CLOCK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        src[SRC_RAM]   = 16'hAB55;
        src[SRC_PC]    = 16'h1080;
        src[SRC_R1]    = 16'h2222;
        src[SRC_R2]    = 16'h3333;
        src[SRC_TR]    = 16'h4444;
        src[SRC_R]     = 16'h5555;
        src[SRC_AC]    = 16'h00C0;
        src[SRC_INSTR] = 16'hF7A5;
        RESET_N = 1'b0; MODE = MODE_ARB; REQ = 8'hFF; SEL_VALID = 1'b0; SELECT = 3'd0;

        // Reset with requests pending.
        cyc(with6(mk(16'h0000, 0, 8'h00, 3'd0), 16'h0000, 0, 0));
        cyc(with6(mk(16'h0000, 0, 8'h00, 3'd0), 16'h0000, 0, 0));

        // Direct mode: narrow then wide source.
        RESET_N = 1'b1; MODE = MODE_DIRECT; SEL_VALID = 1'b1; SELECT = 3'd0;
        cyc(with6(mk(16'h0055, 1, 8'h00, 3'd0), 16'h0055, 1, 0));
        SELECT = 3'd1;
        cyc(with6(mk(16'h1080, 1, 8'h00, 3'd1), 16'h1080, 1, 0));
        SEL_VALID = 1'b0;
        cyc(with6(mk(16'h1080, 0, 8'h00, 3'd1), 16'h1080, 0, 0));
        // SELECT=7: valid narrow source on 8-src, out of range on 6-src.
        SEL_VALID = 1'b1; SELECT = 3'd7;
        cyc(with6(mk(16'h00A5, 1, 8'h00, 3'd7), 16'h1080, 0, 1));
        SEL_VALID = 1'b0;
        cyc(with6(mk(16'h00A5, 0, 8'h00, 3'd7), 16'h1080, 0, 0));

        // Release handoff.
        MODE = MODE_ARB; REQ = 8'b0010_0100;
        cyc(mk(16'h2222, 1, 8'b0000_0100, 3'd2));
        REQ = 8'b0010_0000;
        cyc(mk(16'h5555, 1, 8'b0010_0000, 3'd5));
        REQ = 8'h00;                               // PTR becomes 6, go idle
        cyc(mk(16'h5555, 0, 8'h00, 3'd5));

        // Hold limit with sources 1 and 3 contending.
        REQ = 8'b0000_1010;
        for (int k = 0; k < 9; k++) begin
            int o;
            o = (k >= 4 && k < 8) ? 3 : 1;
            cyc(mk((o == 3) ? 16'h3333 : 16'h1080, 1, 8'(1 << o), 3'(o)));
        end

        // Hand to source 6, then leave arbitration while owned.
        REQ = 8'b0100_0000;                        // PTR becomes 2
        cyc(mk(16'h00C0, 1, 8'b0100_0000, 3'd6));
        MODE = MODE_DIRECT; SEL_VALID = 1'b1; SELECT = 3'd0;
        cyc(mk(16'h00C0, 0, 8'h00, 3'd6));
        SEL_VALID = 1'b0;
        cyc(mk(16'h00C0, 0, 8'h00, 3'd6));
        // Back to arbitration: PTR=2 preserved, so 3 wins over 1.
        MODE = MODE_ARB; REQ = 8'b0000_1010;
        cyc(mk(16'h3333, 1, 8'b0000_1000, 3'd3));

        // Reset mid-ownership, then restart from source 0.
        RESET_N = 1'b0; REQ = 8'hFF;
        cyc(mk(16'h0000, 0, 8'h00, 3'd0));
        RESET_N = 1'b1;
        cyc(mk(16'h0055, 1, 8'b0000_0001, 3'd0));
        // Live tracking of owner data; upper narrow bits stay masked.
        src[SRC_RAM] = 16'hFF66;
        cyc(mk(16'h0066, 1, 8'b0000_0001, 3'd0));

        @(posedge CLOCK);
        #2;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_b_mux_arbiter.md
Name: bus_b_mux_arbiter

Overview:
Parametrised, registered successor to the processor's bus-B source multiplexer. Drives the shared DATA_W-bit bus B from one of N_SRC sources. Narrow sources are zero-extended. Two modes:
- Direct: the controller selects the source.
- Arbitrated: round-robin ownership among requesting sources, with a bounded hold time.

The bus output is registered, so the datapath sees a clean, glitch-free bus with a valid flag.

Parameters:
N_SRC, 8, number of bus sources (2..16)
DATA_W, 16, bus width in bits
NARROW_W, 8, width of narrow sources; only the low NARROW_W bits are used, upper bits zero-extended
NARROW_MASK, 8'b1000_0001, bit i=1 marks source i as narrow (defaults: RAM data, instruction)
MAX_HOLD, 4, max consecutive cycles an owner keeps the bus while others request (>=1)
SEL_W, $clog2(N_SRC), select/owner index width

Ports:
CLOCK  in  1  system clock, all state on rising edge
RESET_N  in  1  synchronous, active-low reset
MODE  in  1  0 = direct select, 1 = arbitrated
SELECT  in  SEL_W  source index (direct mode)
SEL_VALID  in  1  SELECT is valid this cycle (direct mode)
REQ  in  N_SRC  per-source bus request (arbitrated mode)
SRC_DATA  in  N_SRC*DATA_W  flattened source data, source i at [i*DATA_W +: DATA_W]
BUS  out  DATA_W  registered bus-B value
BUS_VALID  out  1  BUS carries a freshly selected source this cycle
GRANT  out  N_SRC  one-hot current owner, 0 when none (arbitrated mode)
OWNER  out  SEL_W  index of last selected or granted source
SEL_ERR  out  1  one-cycle pulse: direct SELECT >= N_SRC

Behaviour:
- Reset (RESET_N low at edge, overrides everything):
  - BUS=0, BUS_VALID=0, GRANT=0, OWNER=0, SEL_ERR=0.
  - State=IDLE, round-robin pointer PTR=0, hold counter=0.
- Extension: ext(i) = NARROW_MASK[i] ? zero-extended low NARROW_W bits : full DATA_W bits.
- Direct mode (MODE=0), latency 1 cycle:
  - SEL_VALID=1 and SELECT<N_SRC → BUS<=ext(SELECT), BUS_VALID<=1, OWNER<=SELECT.
  - SEL_VALID=1 and SELECT>=N_SRC → SEL_ERR<=1, BUS holds, BUS_VALID<=0.
  - SEL_VALID=0 → BUS holds, BUS_VALID<=0.
  - GRANT stays 0. SEL_ERR is 0 in all other cycles.
- Arbitrated mode (MODE=1), states IDLE and OWNED:
  - pick(p) = first i with REQ[i]=1, scanning p, p+1, …, N_SRC-1, 0, …, p-1.
  - IDLE, any REQ → GRANT<=onehot(pick(PTR)), OWNER<=pick, BUS<=ext(pick), BUS_VALID<=1, count<=1, go to OWNED.
  - IDLE, no REQ → BUS holds, BUS_VALID=0.
  - OWNED, REQ[OWNER]=0 → PTR<=OWNER+1 (mod N_SRC).
    - If other REQ: grant pick(OWNER+1) the same edge (zero dead cycles), count<=1.
    - Else: GRANT<=0, BUS_VALID<=0, BUS holds, go to IDLE.
  - OWNED, REQ[OWNER]=1, count==MAX_HOLD, another REQ present → forced rotation: grant pick(OWNER+1), PTR<=OWNER+1, count<=1.
  - Otherwise stay OWNED: BUS<=ext(OWNER) (tracks live source data), BUS_VALID=1, count saturates at MAX_HOLD.
- Mode switch:
  - MODE change while OWNED → next edge GRANT<=0, BUS_VALID<=0, state IDLE, BUS holds; the new mode acts from the following edge.
  - PTR is preserved across mode switches.
- Reset mid-ownership: grant dropped at the reset edge; first grant after reset starts from source 0.
- SEL_VALID and SELECT are ignored in arbitrated mode; REQ is ignored in direct mode.
- SRC_DATA bits above NARROW_W on narrow sources must never reach BUS.

Decomposition:
- Package bus_b_pkg holds:
  - source index constants SRC_RAM=0, SRC_PC=1, SRC_R1=2, SRC_R2=3, SRC_TR=4, SRC_R=5, SRC_AC=6, SRC_INSTR=7;
  - mode constants MODE_DIRECT/MODE_ARB;
  - state encoding ST_IDLE/ST_OWNED.
- One sub-module: bus_b_rr_pick, a combinational round-robin picker (REQ, PTR → index, found).

Test Plan:
- Reset: RESET_N=0 with REQ=8'hFF, MODE=1, 2 edges → BUS=0, BUS_VALID=0, GRANT=0, OWNER=0, SEL_ERR=0.
- Direct narrow/wide (defaults): src0=16'hAB55, SELECT=0, SEL_VALID=1 → next cycle BUS=16'h0055, BUS_VALID=1. Then src1=16'h1080, SELECT=1 → BUS=16'h1080, OWNER=1.
- Select error (N_SRC=6): BUS=16'h1080, then SELECT=7, SEL_VALID=1 → SEL_ERR=1 for exactly 1 cycle, BUS stays 16'h1080, BUS_VALID=0.
- Release handoff: MODE=1, IDLE, PTR=0, REQ=8'b0010_0100 → GRANT=8'b0000_0100, OWNER=2. Drop REQ[2] → next edge GRANT=8'b0010_0000, BUS=ext(5), no BUS_VALID gap.
- Hold limit (MAX_HOLD=4): REQ[1] and REQ[3] held high → OWNER sequence 1,1,1,1,3,3,3,3,1…; BUS_VALID continuously 1.
- Disruption: while OWNED by 6 (src6=16'h00C0), toggle MODE to 0 → GRANT=0, BUS_VALID=0, BUS=16'h00C0 held. Separately, assert RESET_N=0 mid-ownership → all outputs zero; after release with REQ=8'hFF the first GRANT is 8'b0000_0001.
